regfile_wb_arbiter: RTL
=======================

Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port (we3/wa3/wd3) between two writeback requesters: A (ALU result) and B (load data).
- Arbitration is round-robin over a valid/ready handshake, followed by one registered output stage that drives the regfile write port directly.
- Writes to R15 are diverted to a PC-update output; rf[15] is never written, because R15 reads return the PC+8 input.
- Provides same-cycle forwarding for the two regfile read ports and a saturating conflict counter.

Parameters:
- DATA_WIDTH, 32, register data width
- ADDR_WIDTH, 4, register address width (16 registers)
- PC_ADDR, 15, address diverted to the PC-update outputs
- CNT_WIDTH, 16, conflict counter width

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- stall  in  1  blocks all grants while high
- a_valid  in  1  requester A has a write
- a_ready  out  1  requester A accepted this cycle (combinational)
- a_addr  in  ADDR_WIDTH  requester A destination register
- a_data  in  DATA_WIDTH  requester A write data
- b_valid  in  1  requester B has a write
- b_ready  out  1  requester B accepted this cycle (combinational)
- b_addr  in  ADDR_WIDTH  requester B destination register
- b_data  in  DATA_WIDTH  requester B write data
- ra1  in  ADDR_WIDTH  regfile read address 1 (snooped)
- ra2  in  ADDR_WIDTH  regfile read address 2 (snooped)
- we3  out  1  regfile write enable
- wa3  out  ADDR_WIDTH  regfile write address
- wd3  out  DATA_WIDTH  regfile write data
- pcwe  out  1  PC write pulse
- pcwd  out  DATA_WIDTH  PC write data
- fwd1_hit  out  1  ra1 matches the in-flight write
- fwd1_data  out  DATA_WIDTH  forwarded data for ra1
- fwd2_hit  out  1  ra2 matches the in-flight write
- fwd2_data  out  DATA_WIDTH  forwarded data for ra2
- conflict_cnt  out  CNT_WIDTH  cycles with both valid and stall low

Behaviour:
- Reset values (synchronous): we3=0, wa3=0, wd3=0, pcwe=0, pcwd=0, conflict_cnt=0, prio=A.
- Reset mid-operation: any in-flight registered write is discarded, so we3 and pcwe are 0 in the cycle after the reset edge.
- Arbitration state: a 1-bit prio register (A or B).
  - a_ready = !reset && !stall && (!b_valid || prio==A)
  - b_ready = !reset && !stall && (!a_valid || prio==B)
  - Ready depends on the other requester's valid only, never on its own valid.
- Accept: a requester is accepted when valid && ready; at most one accept per cycle.
- prio update: after accepting A, prio<=B; after accepting B, prio<=A; no accept leaves prio unchanged.
  - With both valid, grants therefore alternate strictly, so neither requester starves.
- Latency: exactly one cycle from the accept edge to we3/pcwe asserted; the regfile then commits on the following edge.
- Output stage, on an accepted write with address X and data D:
  - X!=PC_ADDR: we3<=1, wa3<=X, wd3<=D, pcwe<=0.
  - X==PC_ADDR: pcwe<=1, pcwd<=D, we3<=0, wa3/wd3 hold.
- Output stage, no accept: we3<=0 and pcwe<=0; wa3, wd3 and pcwd hold their values.
- Same address from A and B in one cycle: the arbiter serialises them in grant order. The later grant's value persists, and the arbiter does not enforce program order.
- Stall: both ready low and no accept. An already-registered write still issues its single we3/pcwe pulse.
- Forwarding (combinational): fwd1_hit = we3 && ra1==wa3 && ra1!=PC_ADDR; fwd1_data = wd3 when fwd1_hit, else 0. fwd2 is identical using ra2.
- conflict_cnt: increments when a_valid && b_valid && !stall, saturates at all-ones, and clears only on reset.

Decomposition:
- Shared package regfile_pkg:
  - DATA_WIDTH, ADDR_WIDTH, PC_ADDR constants
  - a wb_req_t struct (valid, addr, data)
- One sub-module, rr_arb2: 2-way round-robin arbiter holding the prio flop. Inputs are the two valids and stall; outputs are the two readys.
- The output stage, forwarding and counter stay in the top module.

Test Plan:
- Reset, then A only: a_addr=1, a_data=22220000 for one cycle -> a_ready=1; next cycle we3=1, wa3=1, wd3=22220000; the following cycle we3=0.
- Both valid for 4 cycles, A: R2/11110000, B: R3/33330000, holding each until accepted -> grants A,B,A,B; we3 pulses 4 consecutive cycles alternating wa3 2,3,2,3; conflict_cnt=4 if both requesters remain valid.
- B writes R15=AAAA0000 -> pcwe=1, pcwd=AAAA0000, we3=0, wa3/wd3 unchanged.
- A writes R5=FFEEDDCC with ra1=5, ra2=F -> in the we3 cycle fwd1_hit=1, fwd1_data=FFEEDDCC, fwd2_hit=0, fwd2_data=0.
- stall=1 with both valid for 3 cycles -> a_ready=b_ready=0, no we3 pulses, conflict_cnt unchanged; after stall falls, grant goes to the current prio.
- Accept A (R7/77770000), then assert reset on the next edge -> we3=0 after the reset edge, prio=A, conflict_cnt=0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and writeback request payload for the regfile writeback path.
package regfile_pkg;

   localparam int unsigned DATA_WIDTH = 32;
   localparam int unsigned ADDR_WIDTH = 4;
   localparam int unsigned PC_ADDR    = 15;
   localparam int unsigned CNT_WIDTH  = 16;

   typedef enum logic {
      PRIO_A = 1'b0,
      PRIO_B = 1'b1
   } prio_e;

   typedef struct packed {
      logic                  valid;
      logic [ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0] data;
   } wb_req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the priority flop flips to the other side after each grant.
module rr_arb2
   import regfile_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic i_stall,
   input  logic i_a_valid,
   input  logic i_b_valid,
   output logic o_a_ready_c,
   output logic o_b_ready_c
);

   prio_e r_prio;
   prio_e w_prio_nxt;
   logic  w_a_rdy;
   logic  w_b_rdy;

   always_ff @(posedge clk) begin
      if (reset) r_prio <= PRIO_A;
      else       r_prio <= w_prio_nxt;
   end

   // Ready looks only at the competitor's valid so a requester never waits on itself.
   always_comb begin
      w_prio_nxt = r_prio;
      w_a_rdy    = 1'b0;
      w_b_rdy    = 1'b0;
      if (!reset && !i_stall) begin
         w_a_rdy = !i_b_valid || (r_prio == PRIO_A);
         w_b_rdy = !i_a_valid || (r_prio == PRIO_B);
         if (i_a_valid && w_a_rdy)      w_prio_nxt = PRIO_B;
         else if (i_b_valid && w_b_rdy) w_prio_nxt = PRIO_A;
      end
   end

   assign o_a_ready_c = w_a_rdy;
   assign o_b_ready_c = w_b_rdy;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the regfile write port between ALU (A) and load (B) writeback, diverting
// R15 writes to the PC, with read-port forwarding and a saturating conflict counter.
module regfile_wb_arbiter
   import regfile_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = regfile_pkg::DATA_WIDTH,
   parameter int unsigned ADDR_WIDTH = regfile_pkg::ADDR_WIDTH,
   parameter int unsigned PC_ADDR    = regfile_pkg::PC_ADDR,
   parameter int unsigned CNT_WIDTH  = regfile_pkg::CNT_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  stall,
   input  logic                  a_valid,
   output logic                  a_ready,
   input  logic [ADDR_WIDTH-1:0] a_addr,
   input  logic [DATA_WIDTH-1:0] a_data,
   input  logic                  b_valid,
   output logic                  b_ready,
   input  logic [ADDR_WIDTH-1:0] b_addr,
   input  logic [DATA_WIDTH-1:0] b_data,
   input  logic [ADDR_WIDTH-1:0] ra1,
   input  logic [ADDR_WIDTH-1:0] ra2,
   output logic                  we3,
   output logic [ADDR_WIDTH-1:0] wa3,
   output logic [DATA_WIDTH-1:0] wd3,
   output logic                  pcwe,
   output logic [DATA_WIDTH-1:0] pcwd,
   output logic                  fwd1_hit,
   output logic [DATA_WIDTH-1:0] fwd1_data,
   output logic                  fwd2_hit,
   output logic [DATA_WIDTH-1:0] fwd2_data,
   output logic [CNT_WIDTH-1:0]  conflict_cnt
);

   localparam logic [ADDR_WIDTH-1:0] PC_A = ADDR_WIDTH'(PC_ADDR);

   logic                  w_a_ready;
   logic                  w_b_ready;
   wb_req_t               w_sel;
   logic                  w_fwd1_hit;
   logic                  w_fwd2_hit;

   logic                  r_we3;
   logic [ADDR_WIDTH-1:0] r_wa3;
   logic [DATA_WIDTH-1:0] r_wd3;
   logic                  r_pcwe;
   logic [DATA_WIDTH-1:0] r_pcwd;
   logic [CNT_WIDTH-1:0]  r_cnt;

   rr_arb2 u_arb (
      .clk         (clk),
      .reset       (reset),
      .i_stall     (stall),
      .i_a_valid   (a_valid),
      .i_b_valid   (b_valid),
      .o_a_ready_c (w_a_ready),
      .o_b_ready_c (w_b_ready)
   );

   // At most one side is accepted per cycle, so a simple priority mux suffices.
   always_comb begin
      w_sel = '0;
      if (a_valid && w_a_ready) begin
         w_sel.valid = 1'b1;
         w_sel.addr  = a_addr;
         w_sel.data  = a_data;
      end else if (b_valid && w_b_ready) begin
         w_sel.valid = 1'b1;
         w_sel.addr  = b_addr;
         w_sel.data  = b_data;
      end
   end

   // Output stage: R15 goes to the PC port, everything else to the regfile port.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_we3  <= 1'b0;
         r_wa3  <= '0;
         r_wd3  <= '0;
         r_pcwe <= 1'b0;
         r_pcwd <= '0;
      end else if (w_sel.valid) begin
         if (w_sel.addr == PC_A) begin
            r_we3  <= 1'b0;
            r_pcwe <= 1'b1;
            r_pcwd <= w_sel.data;
         end else begin
            r_we3  <= 1'b1;
            r_wa3  <= w_sel.addr;
            r_wd3  <= w_sel.data;
            r_pcwe <= 1'b0;
         end
      end else begin
         r_we3  <= 1'b0;
         r_pcwe <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (a_valid && b_valid && !stall && (r_cnt != {CNT_WIDTH{1'b1}})) begin
         r_cnt <= r_cnt + CNT_WIDTH'(1);
      end
   end

   // R15 reads return PC+8 upstream, so they never forward.
   assign w_fwd1_hit = r_we3 && (ra1 == r_wa3) && (ra1 != PC_A);
   assign w_fwd2_hit = r_we3 && (ra2 == r_wa3) && (ra2 != PC_A);

   assign a_ready      = w_a_ready;
   assign b_ready      = w_b_ready;
   assign we3          = r_we3;
   assign wa3          = r_wa3;
   assign wd3          = r_wd3;
   assign pcwe         = r_pcwe;
   assign pcwd         = r_pcwd;
   assign fwd1_hit     = w_fwd1_hit;
   assign fwd1_data    = w_fwd1_hit ? r_wd3 : '0;
   assign fwd2_hit     = w_fwd2_hit;
   assign fwd2_data    = w_fwd2_hit ? r_wd3 : '0;
   assign conflict_cnt = r_cnt;

endmodule
